// File: rtl/fetch_queue.sv
// Dual-wide fetch->decode instruction queue: takes up to two instructions per cycle, presents the oldest two.
// Latency: one cycle from push to output; zero with FETCH_QUEUE_BYPASS_EN defined and the queue empty.
// Backpressure: in_ready_o drops once fewer than two entries are free; pop_i consumes every valid output slot.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (same-cycle bypass when the queue is empty).
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (clears queue, drops same-cycle push/pop)
//   in_valid0/1_i, in_inst0/1_i, in_pc0/1_i, in_pred_taken0/1_i : fetch pair, in_ready_o
//   pop_i : decode consumes valid slots
//   out_valid0/1_o, inst0/1_o, pc0/1_o, pred_taken_0/1_o : oldest two entries
//   count_o : occupancy
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid0_i,
  input  logic             in_valid1_i,
  input  logic [31:0]      in_inst0_i,
  input  logic [31:0]      in_inst1_i,
  input  logic [31:0]      in_pc0_i,
  input  logic [31:0]      in_pc1_i,
  input  logic             in_pred_taken0_i,
  input  logic             in_pred_taken1_i,
  output logic             in_ready_o,
  input  logic             pop_i,
  output logic             out_valid0_o,
  output logic             out_valid1_o,
  output logic [31:0]      inst0_o,
  output logic [31:0]      inst1_o,
  output logic [31:0]      pc0_o,
  output logic [31:0]      pc1_o,
  output logic             pred_taken_0_o,
  output logic             pred_taken_1_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [31:0]    NOP        = 32'h0000_0013;
  localparam logic [PTR_W:0] READY_MAX  = (PTR_W+1)'(DEPTH - 2);

  logic [31:0]      r_inst [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic             r_pred [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_in_ready;
  logic [1:0]       w_n_in;
  logic [1:0]       w_n_wr;
  logic [1:0]       w_n_out;
  logic             w_bypass;
  logic             w_st_vld0;
  logic             w_st_vld1;
  logic [PTR_W-1:0] w_rd_ptr1;
  logic [PTR_W-1:0] w_wr_ptr1;
  logic [PTR_W:0]   w_count_next;

  assign w_in_ready = (r_count <= READY_MAX);
  assign in_ready_o = w_in_ready;
  assign count_o    = r_count;

  // Slot 1 sitting behind a predicted-taken slot 0 is wrong-path and is dropped.
  always_comb begin
    w_n_in = 2'd0;
    if (w_in_ready && in_valid0_i) begin
      if (!in_valid1_i || in_pred_taken0_i) w_n_in = 2'd1;
      else                                  w_n_in = 2'd2;
    end
  end

  assign w_st_vld0 = (r_count >= (PTR_W+1)'(1));
  assign w_st_vld1 = (r_count >= (PTR_W+1)'(2));
  assign w_n_out   = pop_i ? ({1'b0, w_st_vld0} + {1'b0, w_st_vld1}) : 2'd0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush_i;
  // Bypassed instructions popped in the same cycle never enter storage.
  assign w_n_wr   = (w_bypass && pop_i) ? 2'd0 : w_n_in;
`else
  assign w_bypass = 1'b0;
  assign w_n_wr   = w_n_in;
`endif

  assign w_rd_ptr1    = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr1    = r_wr_ptr + PTR_W'(1);
  assign w_count_next = r_count + {{(PTR_W-1){1'b0}}, w_n_wr}
                                - {{(PTR_W-1){1'b0}}, w_n_out};

  always_comb begin
    out_valid0_o   = w_st_vld0;
    out_valid1_o   = w_st_vld1;
    inst0_o        = w_st_vld0 ? r_inst[r_rd_ptr]  : NOP;
    pc0_o          = w_st_vld0 ? r_pc[r_rd_ptr]    : 32'h0;
    pred_taken_0_o = w_st_vld0 ? r_pred[r_rd_ptr]  : 1'b0;
    inst1_o        = w_st_vld1 ? r_inst[w_rd_ptr1] : NOP;
    pc1_o          = w_st_vld1 ? r_pc[w_rd_ptr1]   : 32'h0;
    pred_taken_1_o = w_st_vld1 ? r_pred[w_rd_ptr1] : 1'b0;
    if (w_bypass) begin
      // Empty queue: mirror whatever this cycle's push would accept.
      out_valid0_o   = (w_n_in >= 2'd1);
      out_valid1_o   = (w_n_in == 2'd2);
      inst0_o        = (w_n_in >= 2'd1) ? in_inst0_i       : NOP;
      pc0_o          = (w_n_in >= 2'd1) ? in_pc0_i         : 32'h0;
      pred_taken_0_o = (w_n_in >= 2'd1) ? in_pred_taken0_i : 1'b0;
      inst1_o        = (w_n_in == 2'd2) ? in_inst1_i       : NOP;
      pc1_o          = (w_n_in == 2'd2) ? in_pc1_i         : 32'h0;
      pred_taken_1_o = (w_n_in == 2'd2) ? in_pred_taken1_i : 1'b0;
    end
  end

  // Storage is never read while invalid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (w_n_wr >= 2'd1) begin
        r_inst[r_wr_ptr] <= in_inst0_i;
        r_pc[r_wr_ptr]   <= in_pc0_i;
        r_pred[r_wr_ptr] <= in_pred_taken0_i;
      end
      if (w_n_wr == 2'd2) begin
        r_inst[w_wr_ptr1] <= in_inst1_i;
        r_pc[w_wr_ptr1]   <= in_pc1_i;
        r_pred[w_wr_ptr1] <= in_pred_taken1_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_out);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_wr);
      r_count  <= w_count_next;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, pop_i;
  logic        in_valid0_i, in_valid1_i, in_pred_taken0_i, in_pred_taken1_i;
  logic [31:0] in_inst0_i, in_inst1_i, in_pc0_i, in_pc1_i;
  logic        in_ready_o, out_valid0_o, out_valid1_o, pred_taken_0_o, pred_taken_1_o;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic [3:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] head;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_queue #(.DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid0_i(in_valid0_i), .in_valid1_i(in_valid1_i),
    .in_inst0_i(in_inst0_i), .in_inst1_i(in_inst1_i),
    .in_pc0_i(in_pc0_i), .in_pc1_i(in_pc1_i),
    .in_pred_taken0_i(in_pred_taken0_i), .in_pred_taken1_i(in_pred_taken1_i),
    .in_ready_o(in_ready_o), .pop_i(pop_i),
    .out_valid0_o(out_valid0_o), .out_valid1_o(out_valid1_o),
    .inst0_o(inst0_o), .inst1_o(inst1_o), .pc0_o(pc0_o), .pc1_o(pc1_o),
    .pred_taken_0_o(pred_taken_0_o), .pred_taken_1_o(pred_taken_1_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic pt0, input logic pop);
    in_valid0_i      = v0;
    in_valid1_i      = v1;
    in_pc0_i         = pc0;
    in_pc1_i         = pc1;
    in_inst0_i       = inst_of(pc0);
    in_inst1_i       = inst_of(pc1);
    in_pred_taken0_i = pt0;
    in_pred_taken1_i = 1'b0;
    pop_i            = pop;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    drive(1'b1, 1'b1, 32'h50, 32'h54, 1'b0, 1'b0);

    // Reset with pushes active
    tick; tick;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_vld0", 32'(out_valid0_o), 32'd0);
    chk("rst_vld1", 32'(out_valid1_o), 32'd0);
    chk("rst_inst0", inst0_o, NOP);
    chk("rst_inst1", inst1_o, NOP);
    chk("rst_pc0", pc0_o, 32'h0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);

    // Fill to full with pairs, no pop
    rst_i = 1'b0;
    drive(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0); tick;
    chk("fill1_count", 32'(count_o), 32'd2);
    chk("fill1_pc0", pc0_o, 32'h0);
    chk("fill1_inst0", inst0_o, inst_of(32'h0));
    drive(1'b1, 1'b1, 32'h8, 32'hC, 1'b0, 1'b0); tick;
    chk("fill2_count", 32'(count_o), 32'd4);
    drive(1'b1, 1'b1, 32'h10, 32'h14, 1'b0, 1'b0); tick;
    chk("fill3_count", 32'(count_o), 32'd6);
    chk("fill3_ready", 32'(in_ready_o), 32'd1);
    drive(1'b1, 1'b1, 32'h18, 32'h1C, 1'b0, 1'b0); tick;
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_ready", 32'(in_ready_o), 32'd0);
    drive(1'b1, 1'b1, 32'h20, 32'h24, 1'b0, 1'b0); tick;
    chk("full_ignored_count", 32'(count_o), 32'd8);
    chk("full_pc0", pc0_o, 32'h0);
    chk("full_pc1", pc1_o, 32'h4);
    chk("full_inst1", inst1_o, inst_of(32'h4));

    // Drain
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick;
    chk("drain1_count", 32'(count_o), 32'd6);
    chk("drain1_pc0", pc0_o, 32'h8);
    chk("drain1_pc1", pc1_o, 32'hC);
    tick;
    chk("drain2_pc0", pc0_o, 32'h10);
    chk("drain2_pc1", pc1_o, 32'h14);
    tick;
    chk("drain3_pc0", pc0_o, 32'h18);
    chk("drain3_pc1", pc1_o, 32'h1C);
    chk("drain3_ready", 32'(in_ready_o), 32'd1);
    tick;
    chk("drain4_count", 32'(count_o), 32'd0);
    chk("drain4_vld0", 32'(out_valid0_o), 32'd0);
    tick;
    chk("pop_empty_count", 32'(count_o), 32'd0);

    // Continuous push/pop across pointer wrap
    drive(1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0); tick;
    chk("wrap_prime_count", 32'(count_o), 32'd2);
    head = 32'h200;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'h208 + 32'(8 * i), 32'h20C + 32'(8 * i), 1'b0, 1'b1);
      tick;
      head = head + 32'h8;
      chk("wrap_count", 32'(count_o), 32'd2);
      chk("wrap_pc0", pc0_o, head);
      chk("wrap_pc1", pc1_o, head + 32'h4);
    end
    chk("wrap_inst1", inst1_o, inst_of(32'h200 + 32'd164));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick;
    chk("wrap_drain_count", 32'(count_o), 32'd0);

    // Predicted-taken slot 0 drops slot 1
    drive(1'b1, 1'b1, 32'h100, 32'h104, 1'b1, 1'b0); tick;
    chk("pt_count", 32'(count_o), 32'd1);
    chk("pt_pc0", pc0_o, 32'h100);
    chk("pt_pred0", 32'(pred_taken_0_o), 32'd1);
    chk("pt_vld1", 32'(out_valid1_o), 32'd0);
    chk("pt_inst1", inst1_o, NOP);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick;
    chk("pt_pop_count", 32'(count_o), 32'd0);

    // Odd occupancy: single then pair
    drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0); tick;
    chk("odd1_count", 32'(count_o), 32'd1);
    drive(1'b1, 1'b1, 32'h304, 32'h308, 1'b0, 1'b0); tick;
    chk("odd2_count", 32'(count_o), 32'd3);
    chk("odd2_pc0", pc0_o, 32'h300);
    chk("odd2_pc1", pc1_o, 32'h304);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick;
    chk("odd3_count", 32'(count_o), 32'd1);
    chk("odd3_pc0", pc0_o, 32'h308);
    chk("odd3_vld1", 32'(out_valid1_o), 32'd0);
    chk("odd3_inst1", inst1_o, NOP);
    chk("odd3_pc1", pc1_o, 32'h0);

    // Fill to 7: ready must already be low
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h400 + 32'(8 * i), 32'h404 + 32'(8 * i), 1'b0, 1'b0);
      tick;
    end
    chk("c7_count", 32'(count_o), 32'd7);
    chk("c7_ready", 32'(in_ready_o), 32'd0);
    // Push ignored while full, pop still works
    drive(1'b1, 1'b1, 32'h500, 32'h504, 1'b0, 1'b1); tick;
    chk("c7_pop_count", 32'(count_o), 32'd5);
    chk("c7_pop_pc0", pc0_o, 32'h404);
    chk("c7_pop_pc1", pc1_o, 32'h408);

    // Flush beats push and pop
    flush_i = 1'b1;
    drive(1'b1, 1'b1, 32'h600, 32'h604, 1'b0, 1'b1); tick;
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_vld0", 32'(out_valid0_o), 32'd0);
    chk("flush_vld1", 32'(out_valid1_o), 32'd0);
    chk("flush_ready", 32'(in_ready_o), 32'd1);
    tick;
    chk("flush_hold_count", 32'(count_o), 32'd0);

    // Push into empty queue with pop: behaviour depends on bypass build
    drive(1'b1, 1'b1, 32'h700, 32'h704, 1'b0, 1'b1);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_vld0", 32'(out_valid0_o), 32'd1);
    chk("byp_vld1", 32'(out_valid1_o), 32'd1);
    chk("byp_pc0", pc0_o, 32'h700);
    chk("byp_pc1", pc1_o, 32'h704);
    chk("byp_inst0", inst0_o, inst_of(32'h700));
    tick;
    chk("byp_count", 32'(count_o), 32'd0);
`else
    chk("nobyp_vld0", 32'(out_valid0_o), 32'd0);
    chk("nobyp_inst0", inst0_o, NOP);
    tick;
    chk("nobyp_count", 32'(count_o), 32'd2);
    chk("nobyp_pc0", pc0_o, 32'h700);
    chk("nobyp_pc1", pc1_o, 32'h704);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
